idrr_pipe_reg: RTL and testbench
================================

IDRR_PIPE_REG -- requirements
Module: idrr_pipe_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the width of the payload (rs, rt, rd, opcode, func, immediate, address) carried per beat.
REQ-002 The block SHALL have parameter CTRL_W, default 10, meaning the width of the control bundle (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Jump).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall-cycle counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream (ID) beat present.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-010 out_valid  output  1  beat present for downstream (RR).
REQ-011 out_ready  input  1  downstream accepts the beat this cycle.
REQ-012 out_data  output  DATA_W  payload of the head beat.
REQ-013 out_ctrl  output  CTRL_W  control bundle of the head beat.
REQ-014 flush  input  1  discard all buffered beats (branch/jump redirect).
REQ-015 cnt_clr  input  1  clear the stall counter.
REQ-016 stall_cnt  output  CNT_W  saturating count of downstream-stall cycles.

Function
REQ-017 The block SHALL hold up to two beats: a main register (drives out_*) and a skid register; beats leave in arrival order.
REQ-018 in_ready SHALL equal NOT skid_valid, driven from a register, with no combinational path from out_ready or flush.
REQ-019 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer when out_valid and out_ready are both 1.
REQ-020 On input transfer with main empty, or main emptied by an output transfer in the same cycle and skid empty: beat SHALL load into main.
REQ-021 On input transfer with main valid and no output transfer: beat SHALL load into skid; in_ready SHALL be 0 the next cycle.
REQ-022 On output transfer with skid valid: skid beat SHALL move to main the next cycle, and skid SHALL become empty (in_ready back to 1).
REQ-023 On output transfer with skid empty and no input transfer: main SHALL become empty.
REQ-024 out_valid SHALL equal main_valid, driven from a register.
REQ-025 out_ctrl SHALL be all-zero whenever out_valid is 0 (bubble carries no RegWrite/MemWrite/Jump); out_data is don't-care then.
REQ-026 Latency: an input beat accepted into empty main SHALL appear on out_* exactly one cycle later.
REQ-027 Throughput: with out_ready held 1, the block SHALL accept and deliver one beat per cycle with no bubbles.
REQ-028 flush=1 SHALL clear main_valid and skid_valid at the next edge; a beat offered in the same cycle SHALL be dropped; an output transfer in that cycle SHALL still count as delivered.
REQ-029 flush SHALL take priority over every concurrent input or output event.
REQ-030 stall_cnt SHALL increment by 1 each cycle out_valid=1 and out_ready=0, saturating at 2^CNT_W-1 (no wrap).
REQ-031 cnt_clr=1 SHALL set stall_cnt to 0 at the next edge, overriding a concurrent increment; flush SHALL NOT affect stall_cnt.

Reset
REQ-032 rst=1 at a clock edge SHALL set main_valid=0, skid_valid=0, in_ready=1, out_valid=0, out_ctrl=0, stall_cnt=0; out_data reset value is don't-care.
REQ-033 rst SHALL override flush, cnt_clr and all handshake activity; reset asserted mid-operation SHALL discard every buffered beat.
REQ-034 The first transfer after reset SHALL be accepted in the first cycle rst=0.

Verification
REQ-035 Streaming: out_ready=1, beats D0..D3 (ctrl 0x3FF) on consecutive cycles -> out_data D0..D3 on consecutive cycles starting 1 cycle after D0, stall_cnt=0.
REQ-036 Skid: out_ready=0, offer D0 then D1 -> both accepted, in_ready=0 after D1 and D2 held off; out_ready=1 -> D0 then D1 delivered in order, in_ready=1 one cycle after D0 leaves.
REQ-037 Flush: main=D0, skid=D1, flush=1 with in_valid=1 (D2) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, D2 never appears.
REQ-038 Counter: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt 15 and held; cnt_clr=1 in the same cycle as a stall -> stall_cnt 0.
REQ-039 Reset mid-stream: two beats buffered, rst=1 for one cycle -> out_valid=0, in_ready=1, stall_cnt=0; next offered beat appears one cycle later.
REQ-040 Random: random in_valid/out_ready/flush (10 percent) against a scoreboard queue -> no loss, duplication or reordering except beats cleared by flush.

Source files
------------

// File: rtl/idrr_pipe_reg.sv
// ID->RR pipeline register: two-entry skid buffer with fully registered in_ready,
// flush for redirects, and a saturating downstream-stall counter.
module idrr_pipe_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && !skid_valid_q;
    assign out_xfer = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // in_ready is low here, so only the drain of the skid entry can happen
            if (out_xfer) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q && !out_xfer) begin
            if (in_xfer) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                skid_ctrl_d  = in_ctrl;
            end
        end else begin
            main_valid_d = in_xfer;
            if (in_xfer) begin
                main_data_d = in_data;
                main_ctrl_d = in_ctrl;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
        end else if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    // bubbles must never carry RegWrite/MemWrite/Jump downstream
    assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_idrr_pipe_reg.sv
// Directed and scoreboarded random checks for idrr_pipe_reg (16-bit data, 4-bit stall counter).
module tb_idrr_pipe_reg;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 10;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    idrr_pipe_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .flush    (flush),
        .cnt_clr  (cnt_clr),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    logic [25:0] sb[$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_out_ctrl",  out_ctrl, 0);
        chk("rst_stall_cnt", stall_cnt, 0);

        // streaming, first beat offered in the first cycle out of reset
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 10'h3FF;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'hD000 + 16'(i);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data",  out_data, 32'hD000 + i);
            chk("stream_ctrl",  out_ctrl, 10'h3FF);
            chk("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end_valid", out_valid, 0);
        chk("stream_end_ctrl",  out_ctrl, 0);
        chk("stream_stall",     stall_cnt, 0);

        // skid
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hA000; in_ctrl = 10'h155;
        tick();
        chk("skid_a0_ready", in_ready, 1);
        chk("skid_a0_data",  out_data, 16'hA000);
        in_data = 16'hA001; in_ctrl = 10'h2AA;
        tick();
        chk("skid_full_ready", in_ready, 0);
        chk("skid_full_data",  out_data, 16'hA000);
        in_data = 16'hA002; in_ctrl = 10'h0F0;
        tick();
        chk("skid_held_ready", in_ready, 0);
        chk("skid_held_data",  out_data, 16'hA000);
        chk("skid_held_ctrl",  out_ctrl, 10'h155);
        chk("skid_stall",      stall_cnt, 2);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("skid_drain_ready", in_ready, 1);
        chk("skid_drain_data",  out_data, 16'hA001);
        chk("skid_drain_ctrl",  out_ctrl, 10'h2AA);
        tick();
        chk("skid_empty_valid", out_valid, 0);
        chk("skid_empty_ctrl",  out_ctrl, 0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_stall", stall_cnt, 0);

        // flush with both entries full and a beat offered
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 10'h3FF; in_data = 16'hB000;
        tick();
        in_data = 16'hB001;
        tick();
        chk("flush_pre_ready", in_ready, 0);
        flush = 1'b1; in_data = 16'hB002;
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_ctrl",  out_ctrl, 0);
        chk("flush_ready", in_ready, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("flush_no_b2", out_valid, 0);
        // flush dropping a beat that in_ready would otherwise accept
        in_valid = 1'b1; in_data = 16'hC000;
        tick();
        chk("flush2_load", out_data, 16'hC000);
        flush = 1'b1; in_data = 16'hC001;
        tick();
        chk("flush2_valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush2_no_c1", out_valid, 0);

        // counter saturation and clear
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr0", stall_cnt, 0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'hE000; in_ctrl = 10'h001;
        tick();
        in_valid = 1'b0;
        chk("cnt_load", stall_cnt, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_5", stall_cnt, 5);
        for (int i = 0; i < 15; i++) tick();
        chk("cnt_sat", stall_cnt, 15);
        tick();
        chk("cnt_sat_hold", stall_cnt, 15);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr_over_inc", stall_cnt, 0);
        tick();
        chk("cnt_resume", stall_cnt, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("cnt_flush_edge", stall_cnt, 2);
        tick();
        chk("cnt_after_flush", stall_cnt, 2);

        // reset mid-stream with two beats buffered
        in_valid = 1'b1; in_data = 16'hF000;
        tick();
        in_data = 16'hF001;
        tick();
        chk("rst_mid_full", in_ready, 0);
        rst = 1'b1; in_valid = 1'b0; flush = 1'b1; cnt_clr = 1'b0;
        tick();
        rst = 1'b0; flush = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_ready", in_ready, 1);
        chk("rst_mid_stall", stall_cnt, 0);
        chk("rst_mid_ctrl",  out_ctrl, 0);
        in_valid = 1'b1; in_data = 16'hF002; in_ctrl = 10'h2C3; out_ready = 1'b1;
        tick();
        chk("rst_mid_next_data", out_data, 16'hF002);
        chk("rst_mid_next_ctrl", out_ctrl, 10'h2C3);
        in_valid = 1'b0;
        tick();
        chk("rst_mid_drain", out_valid, 0);

        // random traffic against an ordered scoreboard
        sb.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 10);
            in_data   = 16'($urandom);
            in_ctrl   = 10'($urandom_range(1, 1023));
            chk("rnd_valid", out_valid, (sb.size() > 0) ? 1 : 0);
            chk("rnd_ready", in_ready, (sb.size() < 2) ? 1 : 0);
            if (sb.size() > 0) chk("rnd_beat", {out_ctrl, out_data}, sb[0]);
            else               chk("rnd_bubble_ctrl", out_ctrl, 0);
            if (flush) begin
                sb.delete();
            end else begin
                logic acc;
                acc = in_valid && (sb.size() < 2);
                if (out_ready && sb.size() > 0) void'(sb.pop_front());
                if (acc) sb.push_back({in_ctrl, in_data});
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
